// File: rtl/locker_pkg.sv
// Shared definitions for the digital-locker passcode path: digit geometry,
// factory code and the programming FSM state encoding.
package locker_pkg;

   localparam int DIGITS  = 4;
   localparam int DIGIT_W = 2;
   localparam int CODE_W  = DIGITS * DIGIT_W;
   localparam int CNT_W   = $clog2(DIGITS);

   localparam logic [CODE_W-1:0] DEFAULT_CODE = 8'b0011_0011;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ENTER1 = 3'd1,
      ST_ENTER2 = 3'd2,
      ST_COMMIT = 3'd3,
      ST_FAIL   = 3'd4
   } prog_state_e;

   function automatic logic is_entering(prog_state_e s);
      return (s == ST_ENTER1) || (s == ST_ENTER2);
   endfunction

endpackage

// File: rtl/locker_digit_collector.sv
// Collects DIGITS button digits into a code word, first digit in the top slot.
// done_o flags the write that fills the last slot; the count then wraps to 0.
module locker_digit_collector
   import locker_pkg::*;
(
   input  logic               clock,
   input  logic               clear_n,
   input  logic               clr_i,
   input  logic               wr_en_i,
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [CODE_W-1:0]  word_o,
   output logic               done_o
);

   logic [CODE_W-1:0] slots_q, slots_d;
   logic [CODE_W-1:0] slots_wr;
   logic [CNT_W-1:0]  count_q, count_d;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_slot
         localparam int LSB = (DIGITS - 1 - gi) * DIGIT_W;
         assign slots_wr[LSB +: DIGIT_W] =
            (wr_en_i && (count_q == CNT_W'(gi))) ? digit_i : slots_q[LSB +: DIGIT_W];
      end
   endgenerate

   always_comb begin
      slots_d = slots_wr;
      count_d = count_q;
      if (clr_i) begin
         slots_d = '0;
         count_d = '0;
      end else if (wr_en_i) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         slots_q <= '0;
         count_q <= '0;
      end else begin
         slots_q <= slots_d;
         count_q <= count_d;
      end
   end

   assign word_o = slots_q;
   assign done_o = wr_en_i && (count_q == CNT_W'(DIGITS - 1));

endmodule

// File: rtl/locker_code_programmer.sv
// Passcode writer: while unlocked, accepts a new code entered twice identically
// and publishes it on code; everything else leaves the current code untouched.
module locker_code_programmer #(
   parameter logic [locker_pkg::CODE_W-1:0] DEFAULT_CODE = locker_pkg::DEFAULT_CODE,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                           clock,
   input  logic                           clear_n,
   input  logic [locker_pkg::DIGIT_W-1:0] bn,
   input  logic                           bn_valid,
   input  logic                           prog_req,
   input  logic                           cancel,
   input  logic                           unlocked,
   output logic [locker_pkg::CODE_W-1:0]  code,
   output logic                           prog_active,
   output logic                           prog_ok,
   output logic                           prog_fail
);
   import locker_pkg::*;

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   prog_state_e       state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              prog_active_q, prog_ok_q, prog_fail_q;
   logic              s1_wr, s2_wr, s1_done, s2_done, timeout;
   logic [CODE_W-1:0] s1_word, s2_word, s2_full;

   assign s1_wr   = (state_q == ST_ENTER1) && bn_valid && !cancel;
   assign s2_wr   = (state_q == ST_ENTER2) && bn_valid && !cancel;
   assign timeout = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) && !bn_valid;
   // The final confirm digit always lands in the bottom slot, so merge it here.
   assign s2_full = {s2_word[CODE_W-1:DIGIT_W], bn};

   locker_digit_collector u_stage1 (
      .clock   (clock),
      .clear_n (clear_n),
      .clr_i   (state_q == ST_IDLE),
      .wr_en_i (s1_wr),
      .digit_i (bn),
      .word_o  (s1_word),
      .done_o  (s1_done)
   );

   locker_digit_collector u_stage2 (
      .clock   (clock),
      .clear_n (clear_n),
      .clr_i   (state_q != ST_ENTER2),
      .wr_en_i (s2_wr),
      .digit_i (bn),
      .word_o  (s2_word),
      .done_o  (s2_done)
   );

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      code_d  = code_q;
      case (state_q)
         ST_IDLE: begin
            timer_d = '0;
            if (prog_req) state_d = unlocked ? ST_ENTER1 : ST_FAIL;
         end
         ST_ENTER1, ST_ENTER2: begin
            timer_d = bn_valid ? '0 : timer_q + 1'b1;
            if (cancel)
               state_d = ST_IDLE;
            else if (s1_done)
               state_d = ST_ENTER2;
            else if (s2_done)
               state_d = (s2_full == s1_word) ? ST_COMMIT : ST_FAIL;
            else if (timeout)
               state_d = ST_FAIL;
            if (state_d != state_q) timer_d = '0;
         end
         ST_COMMIT: begin
            code_d  = s1_word;
            state_d = ST_IDLE;
         end
         ST_FAIL: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q       <= ST_IDLE;
         timer_q       <= '0;
         code_q        <= DEFAULT_CODE;
         prog_active_q <= 1'b0;
         prog_ok_q     <= 1'b0;
         prog_fail_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         code_q        <= code_d;
         prog_active_q <= is_entering(state_d);
         prog_ok_q     <= (state_q == ST_COMMIT);
         prog_fail_q   <= (state_q == ST_FAIL);
      end
   end

   assign code        = code_q;
   assign prog_active = prog_active_q;
   assign prog_ok     = prog_ok_q;
   assign prog_fail   = prog_fail_q;

endmodule

// File: doc/locker_code_programmer.md
Name: locker_code_programmer

Overview:
- Writer side of the digital-locker passcode: captures a new 4-digit code entered on the 2-bit buttons and holds the 8-bit code word that the door-check FSM compares against.
- Programming is allowed only while the locker reports unlocked.
- A new code is committed only if it is entered twice identically.
- Sits between the button front-end and the door-check FSM, replacing its hard-wired code constant.

Parameters:
- DEFAULT_CODE, 8'b00110011, code loaded at reset; digit 1 is in [7:6], digit 4 is in [1:0].
- TIMEOUT_CYCLES, 1000, maximum idle cycles allowed between digits during programming before the attempt is aborted as a failure.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- clear_n  input  1  reset.
- bn  input  2  button digit value (bits [2:1]); sampled only when bn_valid=1.
- bn_valid  input  1  one-cycle strobe, one per digit press.
- prog_req  input  1  request to start programming; level or pulse.
- cancel  input  1  abort programming.
- unlocked  input  1  high while the door-check FSM is in its code-accepted state.
- code  output  8  current passcode word, consumed by the door-check FSM.
- prog_active  output  1  high while in ENTER1/ENTER2.
- prog_ok  output  1  one-cycle pulse on commit.
- prog_fail  output  1  one-cycle pulse on rejection, mismatch or timeout.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
  - Clock is `clock`; reset is `clear_n`.
  - clear_n=0 immediately forces: code=DEFAULT_CODE, state IDLE, prog_active=0, prog_ok=0, prog_fail=0, digit count=0, timer=0, both stage registers=0.
- All outputs are registered.
- States: IDLE, ENTER1, ENTER2, COMMIT, FAIL.
- IDLE:
  - prog_req=1 and unlocked=1: go to ENTER1; clear digit count and timer.
  - prog_req=1 and unlocked=0: go to FAIL.
  - bn_valid is ignored.
- ENTER1:
  - Each bn_valid writes bn into stage1 at slot (digit count), with slot 0 = [7:6].
  - The digit count increments; the timer clears.
  - On the 4th digit: go to ENTER2, with count and timer cleared.
- ENTER2:
  - Same collection, into stage2.
  - On the 4th digit: go to COMMIT if stage2 (including the digit arriving this cycle) equals stage1; otherwise go to FAIL.
- Timer (ENTER1/ENTER2):
  - Increments on every cycle without bn_valid.
  - At TIMEOUT_CYCLES-1 the next state is FAIL.
  - bn_valid in the same cycle wins over timeout.
- cancel=1 in ENTER1/ENTER2:
  - Go to IDLE; no pulse; code unchanged.
  - cancel has priority over bn_valid and timeout.
- COMMIT (one cycle): on the exiting edge, code<=stage1 and prog_ok<=1 for one cycle; then go to IDLE.
- FAIL (one cycle): prog_fail<=1 for one cycle; go to IDLE; code unchanged.
- Latency: 4th confirm digit sampled at edge k → COMMIT during cycle k → code updated and prog_ok high after edge k+1.
- prog_req is ignored outside IDLE.
- unlocked is checked only at entry; it dropping mid-entry does not abort.
- code never changes except at the COMMIT edge or at reset.
- Reset mid-programming discards both stages and restores DEFAULT_CODE.

Decomposition:
- Shared package locker_pkg:
  - state encoding (3-bit enum, IDLE=0), DIGITS=4, DIGIT_W=2, DEFAULT_CODE constant.
  - Used by this block and the door-check FSM.
- Sub-module locker_digit_collector:
  - 4x2-bit slot register, 2-bit count, done flag, synchronous clear input.
  - Instantiated twice (stage1, stage2).
- Timer and FSM stay in the top module.

Test Plan:
1. Reset → code=8'h33, prog_active=0, prog_ok=0, prog_fail=0; the door-check FSM accepts digits 0,3,0,3.
2. Successful change:
   - Stimulus: unlocked=1, prog_req pulse, digits 2,1,3,0 then 2,1,3,0.
   - Response: prog_ok pulses exactly once, 2 edges after the last bn_valid; code=8'b10011100; prog_active=1 from the cycle after prog_req through the last digit.
3. Locked rejection: unlocked=0 and prog_req=1 → prog_fail single pulse; code stays 8'h33; prog_active never asserts.
4. Mismatch: digits 2,1,3,0 then 2,1,3,1 → prog_fail pulse; code unchanged 8'h33.
5. Timeout (TIMEOUT_CYCLES=8 in the bench):
   - Enter 2 digits, then no bn_valid for 8 cycles → prog_fail pulse; IDLE; code unchanged.
   - A digit arriving on cycle 7 instead keeps programming active.
6. Interruptions:
   - cancel after 3 confirm digits → IDLE, no pulse, code unchanged.
   - clear_n low mid-ENTER2 → outputs reset immediately, code=8'h33.
